// File: rtl/digital_clock_pkg.sv
// Shared definitions for the digital clock time-setting path.
//   state_t     : controller states (RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT)
//   FS_*        : field_sel encodings driven to the LCD string builder
//   HOUR_MAX,
//   MINSEC_MAX  : two-digit field limits, held as packed BCD {tens, units}
//   bcd_step()  : wrap-around BCD increment/decrement of a two-digit field
package digital_clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HOUR,
        ST_SET_MIN,
        ST_SET_SEC,
        ST_COMMIT
    } state_t;

    typedef logic [1:0] field_t;

    localparam field_t FS_NONE = 2'd0;
    localparam field_t FS_HOUR = 2'd1;
    localparam field_t FS_MIN  = 2'd2;
    localparam field_t FS_SEC  = 2'd3;

    // Packed BCD: 23 and 59.
    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // One step of a two-digit BCD field {tens, units} with wrap at 00/max.
    // Valid BCD compares correctly as a plain binary number, so >= also
    // pulls an out-of-range snapshot back to 00 on the first up step.
    function automatic logic [7:0] bcd_step(input logic [7:0] val,
                                            input logic       inc,
                                            input logic [7:0] max);
        if (inc) begin
            if (val >= max)        return 8'h00;
            if (val[3:0] >= 4'd9)  return {val[7:4] + 4'd1, 4'd0};
            return {val[7:4], val[3:0] + 4'd1};
        end else begin
            if (val == 8'h00)      return max;
            if (val[3:0] == 4'd0)  return {val[7:4] - 4'd1, 4'd9};
            return {val[7:4], val[3:0] - 4'd1};
        end
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Key / time / load bundle between the time-setting controller and its
// surroundings (debouncers, watch counter, LCD string builder).
//   btn_mode/up/down      : debounced active-high key levels
//   sec_1 .. hour_10      : running BCD time from the watch
//   load, ld_*            : commit pulse and edited BCD time to the watch
//   set_active, field_sel,
//   blink                 : edit status for the watch and the display
// Modports: slave = controller side, master = environment side.
interface time_set_ctrl_if;

    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;

    logic [3:0] sec_1;
    logic [2:0] sec_10;
    logic [3:0] min_1;
    logic [2:0] min_10;
    logic [3:0] hour_1;
    logic [1:0] hour_10;

    logic       load;
    logic [3:0] ld_sec_1;
    logic [2:0] ld_sec_10;
    logic [3:0] ld_min_1;
    logic [2:0] ld_min_10;
    logic [3:0] ld_hour_1;
    logic [1:0] ld_hour_10;

    logic       set_active;
    logic [1:0] field_sel;
    logic       blink;

    modport slave (
        input  btn_mode, btn_up, btn_down,
        input  sec_1, sec_10, min_1, min_10, hour_1, hour_10,
        output load,
        output ld_sec_1, ld_sec_10, ld_min_1, ld_min_10, ld_hour_1, ld_hour_10,
        output set_active, field_sel, blink
    );

    modport master (
        output btn_mode, btn_up, btn_down,
        output sec_1, sec_10, min_1, min_10, hour_1, hour_10,
        input  load,
        input  ld_sec_1, ld_sec_10, ld_min_1, ld_min_10, ld_hour_1, ld_hour_10,
        input  set_active, field_sel, blink
    );

endinterface

// File: rtl/btn_repeat.sv
// Edge detect plus auto-repeat for one key.
//   clk, rst : clock, async active-high reset
//   en       : low on the first cycle after reset so a key held through
//              reset release is not seen as a press
//   level    : debounced key level
//   clr      : both up/down keys held; kills the step and the repeat state
//   step     : one-cycle step request (press or repeat tick)
// A press steps at once; REPEAT_DLY cycles later one more step, then one
// step every REPEAT_PERIOD cycles while the key stays down. Repeating only
// ever follows a real press, so a key that was cleared must be re-pressed.
module btn_repeat #(
    parameter int REPEAT_DLY    = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic level,
    input  logic clr,
    output logic step
);

    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PERIOD) ? REPEAT_DLY : REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    logic          level_q;
    logic          active;   // hold began with a press, repeat allowed
    logic          rep;      // initial delay done, now in periodic phase
    logic [CW-1:0] cnt;
    logic          press;
    logic          tick;

    assign press = level & ~level_q & en;
    assign tick  = active & level & ~clr & (cnt == (rep ? PER_LAST : DLY_LAST));
    assign step  = (press & ~clr) | tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            active  <= 1'b0;
            rep     <= 1'b0;
            cnt     <= '0;
        end else begin
            level_q <= level;
            if (!level || clr) begin
                active <= 1'b0;
                rep    <= 1'b0;
                cnt    <= '0;
            end else if (press) begin
                active <= 1'b1;
                rep    <= 1'b0;
                cnt    <= '0;
            end else if (active) begin
                if (tick) begin
                    rep <= 1'b1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller. Mode steps RUN -> SET_HOUR -> SET_MIN ->
// SET_SEC -> COMMIT -> RUN; entering SET_HOUR snapshots the live time,
// up/down edit the selected field with BCD wrap, COMMIT pulses load.
//   clk, rst : clock, async active-high reset
//   bus      : time_set_ctrl_if.slave (keys, live time, load/ld_*,
//              set_active, field_sel, blink)
// All outputs are registered and change on the edge that changes state.
module time_set_ctrl
    import digital_clock_pkg::*;
#(
    parameter int REPEAT_DLY    = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int BLINK_HALF    = 12_500_000
) (
    input  logic            clk,
    input  logic            rst,
    time_set_ctrl_if.slave  bus
);

    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    state_t        state_q, state_d;
    field_t        field_d;
    logic          armed;
    logic          mode_q;
    logic          mode_edge;
    logic          both_keys;
    logic          up_step, dn_step;
    logic          in_set;
    logic          edit_step;

    logic [7:0]    hour_q, min_q, sec_q;   // packed BCD edit registers
    logic          load_q, set_active_q, blink_q;
    field_t        field_sel_q;
    logic [BW-1:0] blink_cnt;

    // Key history must see one post-reset sample before edges count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed  <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            armed  <= 1'b1;
            mode_q <= bus.btn_mode;
        end
    end

    assign mode_edge = bus.btn_mode & ~mode_q & armed;
    assign both_keys = bus.btn_up & bus.btn_down;

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
        .clk   (clk),
        .rst   (rst),
        .en    (armed),
        .level (bus.btn_up),
        .clr   (both_keys),
        .step  (up_step)
    );

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dn (
        .clk   (clk),
        .rst   (rst),
        .en    (armed),
        .level (bus.btn_down),
        .clr   (both_keys),
        .step  (dn_step)
    );

    assign in_set = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN) ||
                    (state_q == ST_SET_SEC);
    // Mode wins over a simultaneous step.
    assign edit_step = in_set & ~mode_edge & (up_step | dn_step);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        field_d = FS_NONE;
        case (state_q)
            ST_RUN:      if (mode_edge) state_d = ST_SET_HOUR;
            ST_SET_HOUR: if (mode_edge) state_d = ST_SET_MIN;
            ST_SET_MIN:  if (mode_edge) state_d = ST_SET_SEC;
            ST_SET_SEC:  if (mode_edge) state_d = ST_COMMIT;
            ST_COMMIT:   state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
        case (state_d)
            ST_SET_HOUR: field_d = FS_HOUR;
            ST_SET_MIN:  field_d = FS_MIN;
            ST_SET_SEC:  field_d = FS_SEC;
            default:     field_d = FS_NONE;
        endcase
    end

    // Status outputs and blink timer, registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q       <= 1'b0;
            set_active_q <= 1'b0;
            field_sel_q  <= FS_NONE;
            blink_q      <= 1'b0;
            blink_cnt    <= '0;
        end else begin
            load_q       <= (state_d == ST_COMMIT);
            set_active_q <= (field_d != FS_NONE);
            field_sel_q  <= field_d;
            // Restart the blink phase visible so a change is seen at once.
            if (field_d == FS_NONE || state_d != state_q || edit_step) begin
                blink_q   <= 1'b0;
                blink_cnt <= '0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_q   <= ~blink_q;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Edit registers: snapshot on entry to SET_HOUR, stepped in SET_x.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_q <= 8'h00;
            min_q  <= 8'h00;
            sec_q  <= 8'h00;
        end else if (state_q == ST_RUN && mode_edge) begin
            hour_q <= {2'b00, bus.hour_10, bus.hour_1};
            min_q  <= {1'b0,  bus.min_10,  bus.min_1};
            sec_q  <= {1'b0,  bus.sec_10,  bus.sec_1};
        end else if (edit_step) begin
            // up_step and dn_step are never both set (both_keys clears them).
            case (state_q)
                ST_SET_HOUR: hour_q <= bcd_step(hour_q, up_step, HOUR_MAX);
                ST_SET_MIN:  min_q  <= bcd_step(min_q,  up_step, MINSEC_MAX);
                ST_SET_SEC:  sec_q  <= bcd_step(sec_q,  up_step, MINSEC_MAX);
                default: ;
            endcase
        end
    end

    assign bus.load       = load_q;
    assign bus.set_active = set_active_q;
    assign bus.field_sel  = field_sel_q;
    assign bus.blink      = blink_q;
    assign bus.ld_hour_10 = hour_q[5:4];
    assign bus.ld_hour_1  = hour_q[3:0];
    assign bus.ld_min_10  = min_q[6:4];
    assign bus.ld_min_1   = min_q[3:0];
    assign bus.ld_sec_10  = sec_q[6:4];
    assign bus.ld_sec_1   = sec_q[3:0];

endmodule
